pattern_mult_engine: RTL and testbench

//  Iterative shift-and-combine engine for the pattern-matching datapath. Computes
//  R = combine over all i with q[i]=1 of (p << i), where combine is OR (match mask),
//  XOR (carry-less product) or ADD (integer product).

---
 rtl/pattern_mult_engine.sv | 132 +++++++++++++
 tb/tb_pattern_mult_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_mult_engine.sv
// Iterative shift-and-combine engine: result = combine over set q bits of (p << i),
// with combine selectable as OR (match mask), XOR (carry-less product) or ADD (integer product).
module pattern_mult_engine #(
  parameter int N          = 30,
  parameter int BPC        = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   p,
  input  logic [N-1:0]   q,
  input  logic [1:0]     mode,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result,
  output logic [1:0]     dbg_state
);

  localparam int W2    = 2 * N;
  localparam int STEPS = (BPC >= 1) ? (N / BPC) : 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((BPC < 1) || (BPC > N) || ((N % BPC) != 0)) begin : g_bad_params
    $error("pattern_mult_engine: N must be a multiple of BPC with 1 <= BPC <= N");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready/out_valid are decoded from the state only, so neither side sees a combinational path.
  state_t        state_q, state_d;
  logic [W2-1:0] t_q, t_d;
  logic [W2-1:0] acc_q, acc_d;
  logic [W2-1:0] res_q, res_d;
  logic [N-1:0]  qs_q, qs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;

  logic [W2-1:0] step_acc;
  logic [N-1:0]  qs_next;
  logic          last_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      qs_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      qs_q    <= qs_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    acc_d     = acc_q;
    res_d     = res_q;
    qs_d      = qs_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    step_acc  = acc_q;
    qs_next   = qs_q >> BPC;
    last_step = (cnt_q == CW'(STEPS - 1)) || ((EARLY_EXIT != 0) && (qs_next == '0));

    // Terms of one step are folded in ascending j so ADD carries resolve in order.
    for (int j = 0; j < BPC; j++) begin
      if (qs_q[j]) begin
        case (mode_q)
          2'd1:    step_acc = step_acc ^ (t_q << j);
          2'd2:    step_acc = step_acc + (t_q << j);
          default: step_acc = step_acc | (t_q << j);
        endcase
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          t_d     = {{N{1'b0}}, p};
          qs_d    = q;
          acc_d   = '0;
          cnt_d   = '0;
          mode_d  = mode;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        t_d   = t_q << BPC;
        qs_d  = qs_next;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          res_d   = step_acc;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks both completion and the output handshake; result is left untouched.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pattern_mult_engine.sv
// Bench for pattern_mult_engine: three N=8 instances (BPC1/fixed, BPC1/early-exit, BPC4/fixed)
// share the operand bus; each scenario drives one instance and scores it against a golden model.
module tb_pattern_mult_engine;

  localparam int W  = 8;
  localparam int W2 = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    in_valid, in_ready, out_valid;
  logic [W-1:0]  p, q;
  logic [1:0]    mode;
  logic          abort, out_ready;
  logic [W2-1:0] res [3];
  logic [1:0]    dbg [3];

  logic [W2-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  pattern_mult_engine #(.N(8), .BPC(1), .EARLY_EXIT(0)) u_fix (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .p(p), .q(q),
    .mode(mode), .abort(abort), .out_valid(out_valid[0]), .out_ready(out_ready),
    .result(res[0]), .dbg_state(dbg[0]));

  pattern_mult_engine #(.N(8), .BPC(1), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .p(p), .q(q),
    .mode(mode), .abort(abort), .out_valid(out_valid[1]), .out_ready(out_ready),
    .result(res[1]), .dbg_state(dbg[1]));

  pattern_mult_engine #(.N(8), .BPC(4), .EARLY_EXIT(0)) u_b4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .p(p), .q(q),
    .mode(mode), .abort(abort), .out_valid(out_valid[2]), .out_ready(out_ready),
    .result(res[2]), .dbg_state(dbg[2]));

  function automatic logic [W2-1:0] model(input logic [W-1:0] mp, input logic [W-1:0] mq,
                                          input logic [1:0] mm);
    logic [W2-1:0] acc, term;
    acc = '0;
    for (int i = 0; i < W; i++) begin
      if (mq[i]) begin
        term = {8'h00, mp} << i;
        case (mm)
          2'd1:    acc = acc ^ term;
          2'd2:    acc = acc + term;
          default: acc = acc | term;
        endcase
      end
    end
    return acc;
  endfunction

  function automatic int lat_model(input logic [W-1:0] mq, input int bpc, input int ee);
    int msb;
    if (ee == 0) return W / bpc;
    msb = -1;
    for (int i = 0; i < W; i++) if (mq[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + bpc) / bpc;
  endfunction

  task automatic drive_op(input int sel, input logic [W-1:0] dp, input logic [W-1:0] dq,
                          input logic [1:0] dm);
    p = dp;
    q = dq;
    mode = dm;
    exp_q.push_back(model(dp, dq, dm));
    in_valid[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
  endtask

  task automatic wait_out(input int sel, output int lat, output bit timed_out);
    lat = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid[sel]) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (in_ready[s] !== 1'b1 || out_valid[s] !== 1'b0 || res[s] !== 16'h0000) begin
        failures++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b result=%h, want 1 0 0000",
                 s, in_ready[s], out_valid[s], res[s]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_latency();
    int lat; bit to; logic [W2-1:0] e;
    drive_op(0, 8'h05, 8'h03, 2'd0);
    wait_out(0, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || res[0] !== e) begin
      failures++;
      $display("FAIL fixed_result: got %h (timeout=%0b) want %h", res[0], to, e);
    end
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL fixed_latency: got %0d want 8", lat);
    end
    consume();
  endtask

  task automatic test_early_exit();
    logic [W-1:0] tp [5] = '{8'h05, 8'h05, 8'h01, 8'hA7, 8'h3C};
    logic [W-1:0] tq [5] = '{8'h03, 8'h00, 8'h80, 8'h10, 8'h01};
    int lat, el; bit to; logic [W2-1:0] e;
    for (int k = 0; k < 5; k++) begin
      drive_op(1, tp[k], tq[k], 2'd0);
      wait_out(1, lat, to);
      e = exp_q.pop_front();
      el = lat_model(tq[k], 1, 1);
      checks++;
      if (to || res[1] !== e) begin
        failures++;
        $display("FAIL early_exit_result[%0d]: got %h (timeout=%0b) want %h", k, res[1], to, e);
      end
      checks++;
      if (lat != el) begin
        failures++;
        $display("FAIL early_exit_latency[%0d]: got %0d want %0d", k, lat, el);
      end
      consume();
    end
  endtask

  task automatic test_modes();
    logic [W-1:0]  tp [4] = '{8'hFF, 8'h03, 8'h03, 8'h03};
    logic [W-1:0]  tq [4] = '{8'hFF, 8'h03, 8'h03, 8'h03};
    logic [1:0]    tm [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
    logic [W2-1:0] tr [4] = '{16'hFE01, 16'h0005, 16'h0007, 16'h0007};
    int lat; bit to; logic [W2-1:0] e;
    for (int k = 0; k < 4; k++) begin
      drive_op(0, tp[k], tq[k], tm[k]);
      wait_out(0, lat, to);
      e = exp_q.pop_front();
      checks++;
      if (to || res[0] !== tr[k] || res[0] !== e) begin
        failures++;
        $display("FAIL mode[%0d]: got %h (timeout=%0b) want %h", k, res[0], to, tr[k]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to; logic [W2-1:0] e;
    drive_op(1, 8'h5A, 8'h0F, 2'd1);
    wait_out(1, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || res[1] !== e) begin
      failures++;
      $display("FAIL bp_result: got %h (timeout=%0b) want %h", res[1], to, e);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid[1] = c[0];
      p = 8'($urandom_range(0, 255));
      q = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
      checks++;
      if (out_valid[1] !== 1'b1 || res[1] !== e || in_ready[1] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b result=%h in_ready=%b, want 1 %h 0",
                 c, out_valid[1], res[1], in_ready[1], e);
      end
    end
    in_valid[1] = 1'b0;
    consume();
    checks++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid[1], in_ready[1]);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || res[1] !== e) begin
        failures++;
        $display("FAIL bp_no_ghost[%0d]: out_valid=%b in_ready=%b result=%h, want 0 1 %h",
                 c, out_valid[1], in_ready[1], res[1], e);
      end
    end
  endtask

  task automatic test_rst_abort();
    int lat, seen; bit to; logic [W2-1:0] e;
    drive_op(0, 8'hFF, 8'hFF, 2'd2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || res[0] !== 16'h0000 || in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_run: out_valid=%b result=%h in_ready=%b, want 0 0000 1",
               out_valid[0], res[0], in_ready[0]);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    drive_op(0, 8'h12, 8'h34, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: in_ready=%b out_valid=%b, want 1 0", in_ready[0], out_valid[0]);
    end
    exp_q.delete();
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_output: out_valid cycles=%0d want 0", seen);
    end

    abort = 1'b1;
    drive_op(1, 8'h9D, 8'h26, 2'd2);
    abort = 1'b0;
    wait_out(1, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || res[1] !== e || lat != lat_model(8'h26, 1, 1)) begin
      failures++;
      $display("FAIL abort_in_idle_accept: got %h lat=%0d (timeout=%0b) want %h lat=%0d",
               res[1], lat, to, e, lat_model(8'h26, 1, 1));
    end
    consume();
  endtask

  task automatic test_random_bpc4();
    int lat; bit to; logic [W2-1:0] e;
    logic [W-1:0] rp, rq; logic [1:0] rm;
    for (int k = 0; k < 1000; k++) begin
      rp = 8'($urandom_range(0, 255));
      rq = 8'($urandom_range(0, 255));
      rm = 2'($urandom_range(0, 3));
      drive_op(2, rp, rq, rm);
      wait_out(2, lat, to);
      e = exp_q.pop_front();
      checks++;
      if (to || res[2] !== e) begin
        failures++;
        $display("FAIL rand_result[%0d]: p=%h q=%h mode=%0d got %h want %h",
                 k, rp, rq, rm, res[2], e);
      end
      checks++;
      if (lat != 2) begin
        failures++;
        $display("FAIL rand_latency[%0d]: got %0d want 2", k, lat);
      end
      consume();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = '0;
    p = '0;
    q = '0;
    mode = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_fixed_latency();
    test_early_exit();
    test_modes();
    test_backpressure();
    test_rst_abort();
    test_random_bpc4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
